riscv_lsu: RTL and testbench

- Load/store unit sitting between the instruction decoder and data memory.
- Responder for the decoder's memory request interface: consumes request, write-enable and size; returns the stall request and load data.
- Initiator on the data-memory req/gnt/rvalid bus. Handles one outstanding access.
- Generates byte enables and replicates write data; aligns and sign/zero-extends load data. Flags misaligned accesses and bus timeouts.

---
 rtl/riscv_lsu_pkg.sv | 43 ++++
 rtl/riscv_lsu_data_fmt.sv | 57 +++++
 rtl/riscv_lsu.sv | 182 ++++++++++++++++++
 tb/tb_riscv_lsu.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the LDST_* size encodings (funct3), the FSM state type, byte-enable
// patterns, the lane-offset helper and the misalignment predicate used by
// riscv_lsu and riscv_lsu_data_fmt.
package riscv_lsu_pkg;

  // Access size encodings, identical to the load/store funct3 field.
  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  // Byte-enable patterns for lane 0; shifted up by the lane offset.
  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // Each byte lane is 8 bits wide.
  localparam int unsigned LANE_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_GNT,
    ST_WAIT_RVALID
  } lsu_state_e;

  // Bit offset of a byte lane inside the 32-bit data word.
  function automatic logic [4:0] lane_shift(input logic [1:0] off);
    return {off, 3'b000};
  endfunction

  // Halfwords need an even address, words need a word-aligned address.
  // Byte accesses (and the illegal codes, which act as bytes) never fault.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    case (size)
      LDST_H, LDST_HU: return off[0];
      LDST_W:          return off != 2'b00;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_data_fmt.sv
// Combinational data formatting for the load/store unit.
// Store side: byte-enable generation and lane replication of store data.
// Load side: lane selection and sign/zero extension of read data.
// Ports:
//   st_size, st_off, st_data -> be, st_rep   (store request path)
//   ld_size, ld_off, rdata   -> ld_data      (load response path)
module riscv_lsu_data_fmt
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] st_rep,
  input  logic [2:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] lane;

  // Move the addressed byte/halfword down to bit 0.
  assign lane = rdata >> lane_shift(ld_off);

  // Store path: the byte pattern covers the addressed lanes, and the data
  // is copied into every lane so memory picks whichever lanes are enabled.
  // Illegal size codes fall through to the byte case.
  always_comb begin
    be     = BE_B << st_off;
    st_rep = {4{st_data[7:0]}};
    case (st_size)
      LDST_H, LDST_HU: begin
        be     = BE_H << {st_off[1], 1'b0};
        st_rep = {2{st_data[15:0]}};
      end
      LDST_W: begin
        be     = BE_W;
        st_rep = st_data;
      end
      default: ;
    endcase
  end

  // Load path: extend the selected lane; illegal codes act as signed bytes.
  always_comb begin
    ld_data = {{24{lane[7]}}, lane[7:0]};
    case (ld_size)
      LDST_BU: ld_data = {24'b0, lane[7:0]};
      LDST_H:  ld_data = {{16{lane[15]}}, lane[15:0]};
      LDST_HU: ld_data = {16'b0, lane[15:0]};
      LDST_W:  ld_data = rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit between the decoder and a req/gnt/rvalid data bus.
// One outstanding access. Stalls the core while an access is in flight,
// flags misaligned requests (never sent to the bus) and aborts with a
// one-cycle bus error pulse if gnt or rvalid does not arrive in time.
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   lsu_req_i/we_i/size_i/addr_i/wdata_i   request from decoder
//   lsu_stall_req_o, lsu_data_o       stall and formatted load data
//   lsu_misalign_o, lsu_bus_err_o     exception flags
//   data_req_o/we_o/be_o/addr_o/wdata_o    bus request
//   data_gnt_i, data_rvalid_i, data_rdata_i bus response
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_stall_req_o,
  output logic [31:0] lsu_data_o,
  output logic        lsu_misalign_o,
  output logic        lsu_bus_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e state, state_next;
  logic [CNT_W-1:0] cnt;

  logic        cap_we;
  logic [2:0]  cap_size;
  logic [1:0]  cap_off;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;
  logic [29:0] cap_word;

  logic        misalign;
  logic        req_ok;
  logic        rsp_done;
  logic        timeout_hit;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_ldata;

  riscv_lsu_data_fmt u_fmt (
    .st_size (lsu_size_i),
    .st_off  (lsu_addr_i[1:0]),
    .st_data (lsu_wdata_i),
    .be      (fmt_be),
    .st_rep  (fmt_wdata),
    .ld_size (cap_size),
    .ld_off  (cap_off),
    .rdata   (data_rdata_i),
    .ld_data (fmt_ldata)
  );

  // Requests are masked during reset so every output reads 0 while rst_i
  // is high, even though the decoder may still be presenting a request.
  assign misalign       = is_misaligned(lsu_size_i, lsu_addr_i[1:0]);
  assign req_ok         = ~rst_i & lsu_req_i & ~misalign;
  assign lsu_misalign_o = ~rst_i & lsu_req_i & misalign;
  assign rsp_done       = (state == ST_WAIT_RVALID) & data_rvalid_i;
  assign lsu_bus_err_o  = timeout_hit;

  // The stall drops in the cycle the access finishes (or is aborted), so
  // the decoder moves on at the following edge.
  assign lsu_stall_req_o = req_ok & ~rsp_done & ~timeout_hit;

  // Timeout fires on the last allowed wait cycle only if the awaited
  // handshake is missing; a handshake in that same cycle takes priority.
  always_comb begin
    timeout_hit = 1'b0;
    if (TIMEOUT_EN && cnt == CNT_LAST) begin
      if (state == ST_WAIT_GNT && !data_gnt_i)
        timeout_hit = 1'b1;
      if (state == ST_WAIT_RVALID && !data_rvalid_i)
        timeout_hit = 1'b1;
    end
  end

  // Next-state and bus outputs. The first request cycle drives the bus
  // straight from the core so a same-cycle gnt saves a cycle; while waiting
  // for gnt the bus is driven from the captured copy instead.
  always_comb begin
    state_next   = state;
    data_req_o   = 1'b0;
    data_we_o    = 1'b0;
    data_be_o    = 4'b0;
    data_addr_o  = 32'b0;
    data_wdata_o = 32'b0;
    lsu_data_o   = 32'b0;
    case (state)
      ST_IDLE: begin
        if (req_ok) begin
          data_req_o   = 1'b1;
          data_we_o    = lsu_we_i;
          data_be_o    = fmt_be;
          data_addr_o  = {lsu_addr_i[31:2], 2'b00};
          data_wdata_o = fmt_wdata;
          state_next   = data_gnt_i ? ST_WAIT_RVALID : ST_WAIT_GNT;
        end
      end
      ST_WAIT_GNT: begin
        data_req_o   = 1'b1;
        data_we_o    = cap_we;
        data_be_o    = cap_be;
        data_addr_o  = {cap_word, 2'b00};
        data_wdata_o = cap_wdata;
        if (data_gnt_i)
          state_next = ST_WAIT_RVALID;
        else if (timeout_hit)
          state_next = ST_IDLE;
      end
      ST_WAIT_RVALID: begin
        if (data_rvalid_i) begin
          state_next = ST_IDLE;
          if (!cap_we)
            lsu_data_o = fmt_ldata;
        end else if (timeout_hit) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // Wait-cycle counter: restarts on entry to either wait state and then
  // counts up, sticking at its maximum rather than wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt <= '0;
    else if (state_next != state && state_next != ST_IDLE)
      cnt <= '0;
    else if (state != ST_IDLE && cnt != '1)
      cnt <= cnt + 1'b1;
  end

  // Capture the request when it is first issued so the bus and the load
  // formatter see stable values while waiting for gnt/rvalid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cap_we    <= 1'b0;
      cap_size  <= 3'b0;
      cap_off   <= 2'b0;
      cap_be    <= 4'b0;
      cap_wdata <= 32'b0;
      cap_word  <= 30'b0;
    end else if (state == ST_IDLE && req_ok) begin
      cap_we    <= lsu_we_i;
      cap_size  <= lsu_size_i;
      cap_off   <= lsu_addr_i[1:0];
      cap_be    <= fmt_be;
      cap_wdata <= fmt_wdata;
      cap_word  <= lsu_addr_i[31:2];
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu with a scoreboard: the driver pushes
// expected bus requests and expected core responses into queues, and a
// monitor pops and compares them whenever the DUT hands a request to the
// bus or releases the core.
module tb_riscv_lsu;

  localparam int TO = 4;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsu_req_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [2:0]  lsu_size_i = 3'b0;
  logic [31:0] lsu_addr_i = 32'b0;
  logic [31:0] lsu_wdata_i = 32'b0;
  logic        lsu_stall_req_o;
  logic [31:0] lsu_data_o;
  logic        lsu_misalign_o;
  logic        lsu_bus_err_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = 32'b0;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct packed {
    logic        mis;
    logic        err;
    logic [31:0] data;
  } rsp_exp_t;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];
  bus_exp_t mon_bus;
  rsp_exp_t mon_rsp;

  int checks   = 0;
  int failures = 0;

  riscv_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .lsu_req_i       (lsu_req_i),
    .lsu_we_i        (lsu_we_i),
    .lsu_size_i      (lsu_size_i),
    .lsu_addr_i      (lsu_addr_i),
    .lsu_wdata_i     (lsu_wdata_i),
    .lsu_stall_req_o (lsu_stall_req_o),
    .lsu_data_o      (lsu_data_o),
    .lsu_misalign_o  (lsu_misalign_o),
    .lsu_bus_err_o   (lsu_bus_err_o),
    .data_req_o      (data_req_o),
    .data_we_o       (data_we_o),
    .data_be_o       (data_be_o),
    .data_addr_o     (data_addr_o),
    .data_wdata_o    (data_wdata_o),
    .data_gnt_i      (data_gnt_i),
    .data_rvalid_i   (data_rvalid_i),
    .data_rdata_i    (data_rdata_i)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: access width in bytes; illegal codes act as bytes.
  function automatic int nbytes(input logic [2:0] s);
    if (s == SZ_H || s == SZ_HU) return 2;
    if (s == SZ_W) return 4;
    return 1;
  endfunction

  // Reference model of the load result from the raw bus word.
  function automatic logic [31:0] model_load(input logic [2:0] s, input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] v;
    int n;
    n = nbytes(s);
    v = rd >> (8 * int'(off));
    if (n == 4) return rd;
    if (n == 2) begin
      v = v & 32'h0000_FFFF;
      if (s == SZ_H && v[15]) v = v | 32'hFFFF_0000;
      return v;
    end
    v = v & 32'h0000_00FF;
    if (s != SZ_BU && v[7]) v = v | 32'hFFFF_FF00;
    return v;
  endfunction

  // Reference model of the lane-replicated store word.
  function automatic logic [31:0] model_wrep(input logic [2:0] s, input logic [31:0] wd);
    int n;
    n = nbytes(s);
    if (n == 1) return 32'(wd[7:0]) * 32'h0101_0101;
    if (n == 2) return 32'(wd[15:0]) * 32'h0001_0001;
    return wd;
  endfunction

  // Monitor: compares against the scoreboard whenever the bus accepts a
  // request or the core is released from a request.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_req_o && data_gnt_i) begin
        if (bus_q.size() == 0) begin
          checkOutput("unexpected_bus_req", 32'(data_req_o), 32'd0);
        end else begin
          mon_bus = bus_q.pop_front();
          checkOutput("data_addr", data_addr_o, mon_bus.addr);
          checkOutput("data_be", 32'(data_be_o), 32'(mon_bus.be));
          checkOutput("data_we", 32'(data_we_o), 32'(mon_bus.we));
          if (mon_bus.we)
            checkOutput("data_wdata", data_wdata_o, mon_bus.wdata);
        end
      end
      if (lsu_req_i && lsu_stall_req_o)
        checkOutput("bus_err_while_stalled", 32'(lsu_bus_err_o), 32'd0);
      if (lsu_req_i && !lsu_stall_req_o) begin
        if (rsp_q.size() == 0) begin
          checkOutput("unexpected_release", 32'(lsu_stall_req_o), 32'd1);
        end else begin
          mon_rsp = rsp_q.pop_front();
          checkOutput("misalign", 32'(lsu_misalign_o), 32'(mon_rsp.mis));
          checkOutput("bus_err", 32'(lsu_bus_err_o), 32'(mon_rsp.err));
          checkOutput("load_data", lsu_data_o, mon_rsp.data);
          if (mon_rsp.mis)
            checkOutput("req_on_misalign", 32'(data_req_o), 32'd0);
        end
      end
    end
  end

  // Issue one access. g = cycle (from the request cycle) in which gnt is
  // given, r = extra cycles after the first possible rvalid cycle. Must be
  // called just after a rising edge; returns just after a rising edge.
  task automatic applyStimulus(input logic [2:0] size, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input int g, input int r);
    int n;
    int cyc;
    int stalled;
    int exp_stall;
    logic mis, gnt_to, rv_to;
    bus_exp_t be_e;
    rsp_exp_t rs_e;
    n      = nbytes(size);
    mis    = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
    gnt_to = !mis && (g > TO);
    rv_to  = !mis && !gnt_to && (r >= TO);
    if (mis)         exp_stall = 0;
    else if (gnt_to) exp_stall = TO;
    else if (rv_to)  exp_stall = g + TO;
    else             exp_stall = g + 1 + r;

    rs_e.mis  = mis;
    rs_e.err  = gnt_to | rv_to;
    rs_e.data = (mis || gnt_to || rv_to || we) ? 32'd0 : model_load(size, addr[1:0], rdata);
    rsp_q.push_back(rs_e);
    if (!mis && !gnt_to) begin
      be_e.addr  = addr & 32'hFFFF_FFFC;
      be_e.be    = 4'(((1 << n) - 1) << int'(addr[1:0]));
      be_e.we    = we;
      be_e.wdata = model_wrep(size, wdata);
      bus_q.push_back(be_e);
    end

    lsu_req_i   = 1'b1;
    lsu_we_i    = we;
    lsu_size_i  = size;
    lsu_addr_i  = addr;
    lsu_wdata_i = wdata;
    stalled = 0;
    cyc     = 0;
    forever begin
      data_gnt_i    = !mis && g <= TO && cyc == g;
      data_rvalid_i = !mis && g <= TO && cyc == g + 1 + r;
      if (!mis && cyc < g && ($urandom % 3 == 0))
        data_rvalid_i = 1'b1;
      data_rdata_i  = (data_rvalid_i && cyc > g) ? rdata : $urandom;
      @(negedge clk);
      if (!lsu_stall_req_o) break;
      stalled++;
      cyc++;
      if (cyc > 30) begin
        checkOutput("latency_bound", 32'(cyc), 32'(exp_stall));
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("stall_cycles", 32'(stalled), 32'(exp_stall));
    @(posedge clk);
    #1;
    lsu_req_i     = 1'b0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
  endtask

  // Idle cycles with no request; stray rvalids must be ignored.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      lsu_req_i     = 1'b0;
      lsu_addr_i    = $urandom;
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'($urandom % 2);
      data_rdata_i  = $urandom;
      @(posedge clk);
      #1;
    end
    data_rvalid_i = 1'b0;
  endtask

  initial begin
    logic [2:0]  sz;
    logic [31:0] ad;
    // Outputs stay low during reset even with a live request.
    lsu_req_i  = 1'b1;
    lsu_size_i = SZ_W;
    lsu_addr_i = 32'h0000_0100;
    @(negedge clk);
    checkOutput("rst_stall", 32'(lsu_stall_req_o), 32'd0);
    checkOutput("rst_data_req", 32'(data_req_o), 32'd0);
    lsu_addr_i = 32'h0000_0102;
    @(negedge clk);
    checkOutput("rst_misalign", 32'(lsu_misalign_o), 32'd0);
    checkOutput("rst_data", lsu_data_o, 32'd0);
    @(posedge clk);
    #1;
    lsu_req_i = 1'b0;
    rst       = 1'b0;
    idleCycles(2);

    $display("[TB] directed accesses");
    applyStimulus(SZ_B,  1'b0, 32'h0000_1003, 32'h0,         32'h80AA_BBCC, 0, 0);
    applyStimulus(SZ_H,  1'b1, 32'h0000_2002, 32'h1234_ABCD, 32'h0,         3, 0);
    applyStimulus(SZ_HU, 1'b0, 32'h0000_0001, 32'h0,         32'h0,         0, 0);
    applyStimulus(SZ_W,  1'b0, 32'h0000_0006, 32'h0,         32'h0,         0, 0);
    applyStimulus(SZ_W,  1'b0, 32'h0000_0300, 32'h0,         32'h1111_2222, 0, TO);
    applyStimulus(SZ_W,  1'b0, 32'h0000_0304, 32'h0,         32'h3333_4444, 0, 0);
    applyStimulus(SZ_W,  1'b1, 32'h0000_0308, 32'h5555_6666, 32'h0,         TO + 1, 0);
    applyStimulus(SZ_W,  1'b0, 32'h0000_030C, 32'h0,         32'h7777_8888, TO, TO - 1);
    applyStimulus(SZ_BU, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 0);
    applyStimulus(SZ_W,  1'b0, 32'h0000_0014, 32'h0,         32'hCAFE_F00D, 0, 0);
    applyStimulus(3'b111, 1'b0, 32'h0000_0021, 32'h0,        32'h0000_8000, 1, 1);

    $display("[TB] reset during WAIT_GNT");
    lsu_req_i  = 1'b1;
    lsu_we_i   = 1'b0;
    lsu_size_i = SZ_W;
    lsu_addr_i = 32'h0000_0040;
    @(negedge clk);
    checkOutput("req_before_reset", 32'(data_req_o), 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_drops_req", 32'(data_req_o), 32'd0);
    checkOutput("reset_drops_stall", 32'(lsu_stall_req_o), 32'd0);
    @(posedge clk);
    #1;
    lsu_req_i     = 1'b0;
    rst           = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'hFFFF_FFFF;
    @(negedge clk);
    checkOutput("late_rvalid_data", lsu_data_o, 32'd0);
    checkOutput("late_rvalid_req", 32'(data_req_o), 32'd0);
    @(posedge clk);
    #1;
    data_rvalid_i = 1'b0;
    applyStimulus(SZ_W, 1'b0, 32'h0000_0050, 32'h0,         32'hA5A5_0F0F, 0, 0);
    applyStimulus(SZ_W, 1'b1, 32'h0000_0054, 32'h0BAD_CAFE, 32'h0,         0, 0);

    $display("[TB] randomized accesses");
    for (int t = 0; t < 200; t++) begin
      sz = 3'($urandom_range(0, 7));
      ad = $urandom;
      if ($urandom % 2 == 0) ad[1:0] = 2'b00;
      applyStimulus(sz, 1'($urandom % 2), ad, $urandom, $urandom,
                    int'($urandom_range(0, TO + 2)), int'($urandom_range(0, TO)));
      if ($urandom % 4 == 0) idleCycles(int'($urandom_range(1, 3)));
    end

    idleCycles(2);
    checkOutput("bus_q_drained", 32'(bus_q.size()), 32'd0);
    checkOutput("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
